// File: rtl/instr_encoder.sv
// instr_encoder: assembles symbolic LEGv8 requests into machine words
// and streams them into instruction memory, one word per cycle.
module instr_encoder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 8,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rn,
  input  logic [4:0]        req_rm,
  input  logic [18:0]       req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [CW-1:0]     word_count,
  output logic              full,
  output logic              err
);

  localparam logic [2:0] OP_LDUR = 3'd0;
  localparam logic [2:0] OP_STUR = 3'd1;
  localparam logic [2:0] OP_CBZ  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_AND  = 3'd5;
  localparam logic [2:0] OP_ORR  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  logic        we_q;
  logic        accept;
  logic        legal;
  logic [31:0] enc;

  assign full      = (word_count == CW'(DEPTH));
  assign req_ready = !reset && !full && !clear;
  assign accept    = req_valid && req_ready;
  assign legal     = (req_op != OP_ILL);
  // a pending write is dropped the moment reset is seen
  assign mem_we    = we_q && !reset;

  always_comb begin
    enc = 32'd0;
    unique case (req_op)
      OP_LDUR: enc = {11'b11111000010, req_imm[8:0],
                      2'b00, req_rn, req_rd};
      OP_STUR: enc = {11'b11111000000, req_imm[8:0],
                      2'b00, req_rn, req_rd};
      OP_CBZ:  enc = {8'b10110100, req_imm, req_rd};
      OP_ADD:  enc = {11'b10001011000, req_rm,
                      6'd0, req_rn, req_rd};
      OP_SUB:  enc = {11'b11001011000, req_rm,
                      6'd0, req_rn, req_rd};
      OP_AND:  enc = {11'b10001010000, req_rm,
                      6'd0, req_rn, req_rd};
      OP_ORR:  enc = {11'b10101010000, req_rm,
                      6'd0, req_rn, req_rd};
      OP_ILL:  enc = 32'd0;
      default: enc = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      err        <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (clear) begin
        word_count <= '0;
        err        <= 1'b0;
      end else if (accept) begin
        if (legal) begin
          we_q       <= 1'b1;
          mem_addr   <= ADDR_W'({word_count, 2'b00});
          mem_wdata  <= enc;
          word_count <= word_count + 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed plus randomized scoreboard bench
// for the LEGv8 instruction encoder.
module tb_instr_encoder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;
  localparam int CW     = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              clear = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [2:0]        req_op = '0;
  logic [4:0]        req_rd = '0;
  logic [4:0]        req_rn = '0;
  logic [4:0]        req_rm = '0;
  logic [18:0]       req_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [CW-1:0]     word_count;
  logic              full;
  logic              err;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn),
    .req_rm(req_rm), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .word_count(word_count),
    .full(full), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // expected writes: {byte address, word}
  logic [63:0] expq[$];
  int cnt_m = 0;
  bit err_m = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h want 0x%08h",
                  name, act, exp);
  endtask

  function automatic logic [31:0] model_enc(
      int op, int rd, int rn, int rm, int imm);
    int unsigned w;
    int unsigned r;
    r = (rn << 5) + rd;
    case (op)
      0: w = (32'h7C2 << 21) + ((imm % 512) << 12) + r;
      1: w = (32'h7C0 << 21) + ((imm % 512) << 12) + r;
      2: w = (32'hB4 << 24) + (imm << 5) + rd;
      3: w = (32'h458 << 21) + (rm << 16) + r;
      4: w = (32'h658 << 21) + (rm << 16) + r;
      5: w = (32'h450 << 21) + (rm << 16) + r;
      6: w = (32'h550 << 21) + (rm << 16) + r;
      default: w = 0;
    endcase
    return w;
  endfunction

  always @(negedge clk) begin
    logic [63:0] e;
    if (mem_we) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL spurious_write: got addr 0x%02h want none",
                 mem_addr);
      end else begin
        e = expq.pop_front();
        chk("wr_addr", 32'(mem_addr), e[63:32]);
        chk("wr_data", mem_wdata, e[31:0]);
      end
    end else if (expq.size() != 0) begin
      checks++;
      $display("FAIL missing_write: got mem_we 0 want 1");
      void'(expq.pop_front());
    end
  end

  task automatic check_status();
    chk("word_count", 32'(word_count), cnt_m);
    chk("err", 32'(err), 32'(err_m));
    chk("full", 32'(full), 32'(cnt_m == DEPTH));
  endtask

  // called at posedge+1; ends at next posedge+1
  task automatic step(bit v, int op, int rd, int rn, int rm,
                      int imm, bit clr, logic [31:0] want);
    bit rdy;
    logic [31:0] w;
    req_valid = v;
    req_op    = 3'(op);
    req_rd    = 5'(rd);
    req_rn    = 5'(rn);
    req_rm    = 5'(rm);
    req_imm   = 19'(imm);
    clear     = clr;
    #1;
    rdy = !reset && (cnt_m != DEPTH) && !clr;
    chk("req_ready", 32'(req_ready), 32'(rdy));
    @(posedge clk);
    if (reset) begin
      cnt_m = 0;
      err_m = 0;
    end else if (clr) begin
      cnt_m = 0;
      err_m = 0;
    end else if (v && rdy) begin
      if (op == 7) begin
        err_m = 1;
      end else begin
        w = (want != 0) ? want : model_enc(op, rd, rn, rm, imm);
        expq.push_back({32'(cnt_m * 4), w});
        cnt_m++;
      end
    end
    #1;
    req_valid = 1'b0;
    clear = 1'b0;
    check_status();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    expq.delete();
    #1;
    chk("we_in_reset", 32'(mem_we), 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b0;
  endtask

  initial begin
    int op;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", mem_wdata, 0);
    check_status();
    reset = 1'b0;
    #1;
    chk("ready_after_rst", 32'(req_ready), 1);
    @(posedge clk);
    #1;

    step(1, 3, 3, 1, 2, 0, 0, 32'h8B020023);
    step(1, 4, 3, 1, 2, 0, 0, 32'hCB020023);
    step(1, 0, 1, 2, 0, 8, 0, 32'hF8408041);
    step(1, 1, 1, 2, 0, 0, 0, 32'hF8000041);
    step(1, 2, 5, 0, 0, 3, 0, 32'hB4000065);
    step(1, 5, 3, 1, 2, 0, 0, 32'h8A020023);
    step(1, 6, 3, 1, 2, 0, 0, 32'hAA020023);
    step(1, 7, 9, 9, 9, 9, 0, 0);
    idle();
    step(1, 3, 3, 1, 2, 0, 0, 32'h8B020023);
    step(1, 3, 4, 4, 4, 0, 0, 0);
    step(1, 3, 4, 4, 4, 0, 0, 0);
    step(1, 3, 4, 4, 4, 0, 1, 0);
    step(1, 6, 7, 8, 9, 0, 0, 32'hAA090107);
    step(1, 3, 1, 1, 1, 0, 0, 0);
    do_reset();
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        op = ($urandom_range(0, 9) == 0) ? 7
                                         : $urandom_range(0, 6);
        step($urandom_range(0, 2) != 0, op,
             $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 524287),
             ($urandom_range(0, 24) == 0) ||
             (cnt_m == DEPTH && $urandom_range(0, 2) == 0), 0);
      end
    end
    idle();
    idle();
    chk("queue_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
